// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_arb_pkg: shared encodings for the data-memory port arbiter.
// FSM state and owner encodings are fixed so waveforms and any external
// decoding stay stable across builds.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    // The master that is not o; used for round-robin and the DONE handoff.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_CPU) ? OWN_DBG : OWN_CPU;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: CPU, debug and memory-side signals of the data-memory
// port arbiter. The slave modport is the arbiter's view; master is the view of
// whatever drives the two requesters and models the memory.
interface dmem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic          cpu_req_i;
    logic          cpu_we_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_wdata_i;
    logic          cpu_ack_o;
    logic [DW-1:0] cpu_rdata_o;
    logic          cpu_stall_o;

    logic          dbg_req_i;
    logic          dbg_we_i;
    logic [AW-1:0] dbg_addr_i;
    logic [DW-1:0] dbg_wdata_i;
    logic          dbg_ack_o;
    logic [DW-1:0] dbg_rdata_o;

    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_read_o;
    logic          mem_write_o;
    logic [DW-1:0] mem_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  mem_rdata_i,
        output cpu_ack_o, cpu_rdata_o, cpu_stall_o,
        output dbg_ack_o, dbg_rdata_o,
        output mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output mem_rdata_i,
        input  cpu_ack_o, cpu_rdata_o, cpu_stall_o,
        input  dbg_ack_o, dbg_rdata_o,
        input  mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
    );

endinterface

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// rr_arb2: two-requester combinational picker used when the arbiter is idle.
// req0 is the CPU, req1 the debug master. On a tie the master that did not
// own the port last wins, unless CPU priority is enabled.
// Build option: DMEM_ARB_CPU_PRIO_EN forces CPU priority on every tie.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_e last,
    input  logic   prio_en,
    output owner_e winner
);

    logic use_prio;

`ifdef DMEM_ARB_CPU_PRIO_EN
    assign use_prio = 1'b1 | prio_en;
`else
    assign use_prio = prio_en;
`endif

    // Pick the winner: single requester wins outright, ties use priority or round-robin.
    always_comb begin
        winner = OWN_CPU;
        if (req0 && req1) begin
            winner = use_prio ? OWN_CPU : other_owner(last);
        end else if (req1) begin
            winner = OWN_DBG;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: serialises CPU MEM-stage and debug/loader accesses onto a
// single-port data memory. Every access takes IDLE->BUSY->DONE; the memory is
// strobed in BUSY and the owner is acked in DONE, where a waiting non-owner is
// handed the port directly. cpu_stall_o holds the pipeline until the ack.
// Build option: DMEM_ARB_CPU_PRIO_EN (CPU wins idle ties; see rr_arb2).
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic                clk_i,
    input logic                rst_i,
    dmem_port_arbiter_if.slave bus
);

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    owner_e        pick;
    owner_e        load_src;
    logic          load;
    logic          other_req;
    logic          cpu_ack;
    logic          dbg_ack;

    rr_arb2 u_pick (
        .req0    (bus.cpu_req_i),
        .req1    (bus.dbg_req_i),
        .last    (last_q),
        .prio_en (1'b0),
        .winner  (pick)
    );

    assign other_req = (owner_q == OWN_CPU) ? bus.dbg_req_i : bus.cpu_req_i;

    // State, ownership, latched command and captured read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= OWN_CPU;
            last_q  <= OWN_DBG;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state: grant in IDLE, access in BUSY, ack plus optional handoff in DONE.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        load     = 1'b0;
        load_src = OWN_CPU;

        case (state_q)
            IDLE: begin
                if (bus.cpu_req_i || bus.dbg_req_i) begin
                    load     = 1'b1;
                    load_src = pick;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                rdata_d = we_q ? '0 : bus.mem_rdata_i;
                last_d  = owner_q;
                state_d = DONE;
            end
            DONE: begin
                if (other_req) begin
                    load     = 1'b1;
                    load_src = other_owner(owner_q);
                    state_d  = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            owner_d = load_src;
            if (load_src == OWN_DBG) begin
                we_d    = bus.dbg_we_i;
                addr_d  = bus.dbg_addr_i;
                wdata_d = bus.dbg_wdata_i;
            end else begin
                we_d    = bus.cpu_we_i;
                addr_d  = bus.cpu_addr_i;
                wdata_d = bus.cpu_wdata_i;
            end
        end
    end

    assign cpu_ack = (state_q == DONE) && (owner_q == OWN_CPU);
    assign dbg_ack = (state_q == DONE) && (owner_q == OWN_DBG);

    assign bus.cpu_ack_o   = cpu_ack;
    assign bus.dbg_ack_o   = dbg_ack;
    assign bus.cpu_rdata_o = (owner_q == OWN_CPU) ? rdata_q : '0;
    assign bus.dbg_rdata_o = (owner_q == OWN_DBG) ? rdata_q : '0;
    assign bus.cpu_stall_o = bus.cpu_req_i & ~cpu_ack;

    assign bus.mem_read_o  = (state_q == BUSY) & ~we_q;
    assign bus.mem_write_o = (state_q == BUSY) & we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed bench for dmem_port_arbiter with a small
// word-addressed memory model (combinational read, write on the clock edge).
// Honours DMEM_ARB_CPU_PRIO_EN when choosing expected tie winners.
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_CPU_PRIO_EN
    localparam bit CPU_PRIO = 1'b1;
`else
    localparam bit CPU_PRIO = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_i = ~clk_i;

    logic [31:0] mem [0:63];
    logic        pre_we   = 1'b0;
    logic [5:0]  pre_idx  = '0;
    logic [31:0] pre_data = '0;
    int          write_count = 0;

    assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:2]];

    // Memory model: arbiter writes commit on the clock edge; preload port otherwise.
    always @(posedge clk_i) begin
        if (bus.mem_write_o) begin
            mem[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
            write_count <= write_count + 1;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
    end

    // A master must keep its request up until it has seen its ack.
    assert property (@(posedge clk_i) disable iff (rst_i)
                     $fell(bus.cpu_req_i) |-> $past(bus.cpu_ack_o))
        else $error("[TB] protocol: cpu_req dropped before ack");
    assert property (@(posedge clk_i) disable iff (rst_i)
                     $fell(bus.dbg_req_i) |-> $past(bus.dbg_ack_o))
        else $error("[TB] protocol: dbg_req dropped before ack");

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input bit is_dbg, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (is_dbg) begin
            bus.dbg_req_i   = req;
            bus.dbg_we_i    = we;
            bus.dbg_addr_i  = addr;
            bus.dbg_wdata_i = wdata;
        end else begin
            bus.cpu_req_i   = req;
            bus.cpu_we_i    = we;
            bus.cpu_addr_i  = addr;
            bus.cpu_wdata_i = wdata;
        end
        #1;
    endtask

    task automatic preloadWord(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk_i);
        pre_we   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        @(negedge clk_i);
        pre_we   = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " cpu_ack"},   32'(bus.cpu_ack_o),   32'd0);
        checkOutput({tag, " dbg_ack"},   32'(bus.dbg_ack_o),   32'd0);
        checkOutput({tag, " mem_read"},  32'(bus.mem_read_o),  32'd0);
        checkOutput({tag, " mem_write"}, 32'(bus.mem_write_o), 32'd0);
        checkOutput({tag, " mem_addr"},  bus.mem_addr_o,       32'd0);
        checkOutput({tag, " mem_wdata"}, bus.mem_wdata_o,      32'd0);
        checkOutput({tag, " cpu_rdata"}, bus.cpu_rdata_o,      32'd0);
        checkOutput({tag, " dbg_rdata"}, bus.dbg_rdata_o,      32'd0);
        checkOutput({tag, " cpu_stall"}, 32'(bus.cpu_stall_o), 32'd0);
    endtask

    // Uncontended CPU access: request, BUSY, ack, then drop request after the ack edge.
    task automatic runCpuAccess(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input string tag);
        nextCycle();
        applyStimulus(1'b0, 1'b1, we, addr, wdata);
        checkOutput({tag, " stall in req cycle"}, 32'(bus.cpu_stall_o), 32'd1);
        checkOutput({tag, " no strobe in idle"},
                    32'(bus.mem_read_o | bus.mem_write_o), 32'd0);
        nextCycle();
        checkOutput({tag, " stall in busy"}, 32'(bus.cpu_stall_o), 32'd1);
        checkOutput({tag, " read strobe"},   32'(bus.mem_read_o),  32'(!we));
        checkOutput({tag, " write strobe"},  32'(bus.mem_write_o), 32'(we));
        checkOutput({tag, " mem_addr"},      bus.mem_addr_o,       addr);
        checkOutput({tag, " early ack"},     32'(bus.cpu_ack_o),   32'd0);
        nextCycle();
        checkOutput({tag, " ack"},           32'(bus.cpu_ack_o),   32'd1);
        checkOutput({tag, " rdata"},         bus.cpu_rdata_o,      exp_rdata);
        checkOutput({tag, " stall at ack"},  32'(bus.cpu_stall_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput({tag, " ack is one pulse"}, 32'(bus.cpu_ack_o), 32'd0);
    endtask

    // Both masters request reads in the same idle cycle; dbg_first names the expected winner.
    task automatic tieRound(input logic [31:0] cpu_addr, input logic [31:0] dbg_addr,
                            input bit dbg_first, input logic [31:0] cpu_exp,
                            input logic [31:0] dbg_exp, input string tag);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, cpu_addr, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, dbg_addr, 32'd0);
        nextCycle();
        checkOutput({tag, " winner addr"}, bus.mem_addr_o, dbg_first ? dbg_addr : cpu_addr);
        nextCycle();
        checkOutput({tag, " first ack"},
                    32'(dbg_first ? bus.dbg_ack_o : bus.cpu_ack_o), 32'd1);
        checkOutput({tag, " first rdata"},
                    dbg_first ? bus.dbg_rdata_o : bus.cpu_rdata_o,
                    dbg_first ? dbg_exp : cpu_exp);
        checkOutput({tag, " second ack early"},
                    32'(dbg_first ? bus.cpu_ack_o : bus.dbg_ack_o), 32'd0);
        nextCycle();
        applyStimulus(dbg_first, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput({tag, " handoff addr"}, bus.mem_addr_o, dbg_first ? cpu_addr : dbg_addr);
        checkOutput({tag, " handoff read"}, 32'(bus.mem_read_o), 32'd1);
        nextCycle();
        checkOutput({tag, " second ack"},
                    32'(dbg_first ? bus.cpu_ack_o : bus.dbg_ack_o), 32'd1);
        checkOutput({tag, " second rdata"},
                    dbg_first ? bus.cpu_rdata_o : bus.dbg_rdata_o,
                    dbg_first ? cpu_exp : dbg_exp);
        nextCycle();
        applyStimulus(!dbg_first, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput({tag, " idle acks"}, 32'(bus.cpu_ack_o | bus.dbg_ack_o), 32'd0);
    endtask

    // Main directed sequence.
    initial begin
        int wc0;
        bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
        bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = '0; bus.dbg_wdata_i = '0;

        preloadWord(6'd0,  32'h1111_1111);
        preloadWord(6'd1,  32'h2222_2222);
        preloadWord(6'd4,  32'hDEAD_BEEF);
        preloadWord(6'd8,  32'h0000_0000);
        preloadWord(6'd9,  32'h0000_0000);
        preloadWord(6'd12, 32'hAAAA_0000);
        checkAllZero("reset");
        nextCycle();
        rst_i = 1'b0;

        runCpuAccess(1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, "cpu rd 0x10");

        wc0 = write_count;
        runCpuAccess(1'b1, 32'h20, 32'h1234_5678, 32'd0, "cpu wr 0x20");
        checkOutput("write strobe cycles", 32'(write_count - wc0), 32'd1);
        runCpuAccess(1'b0, 32'h20, 32'd0, 32'h1234_5678, "cpu rd 0x20");

        nextCycle();
        rst_i = 1'b1;
        nextCycle();
        rst_i = 1'b0;
        tieRound(32'h0,  32'h4,  1'b0, 32'h1111_1111, 32'h2222_2222, "tie after reset");
        tieRound(32'h10, 32'h20, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, "tie after dbg last");

        runCpuAccess(1'b0, 32'h0, 32'd0, 32'h1111_1111, "cpu solo");
        for (int i = 0; i < 3; i++) begin
            tieRound(32'h10, 32'h4, !CPU_PRIO, 32'hDEAD_BEEF, 32'h2222_2222,
                     $sformatf("tie after cpu %0d", i));
        end

        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h24, 32'h5555_AAAA);
        checkOutput("b2b cpu busy addr", bus.mem_addr_o, 32'h10);
        nextCycle();
        checkOutput("b2b cpu ack",   32'(bus.cpu_ack_o), 32'd1);
        checkOutput("b2b cpu rdata", bus.cpu_rdata_o,    32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("b2b dbg write strobe", 32'(bus.mem_write_o), 32'd1);
        checkOutput("b2b dbg addr",         bus.mem_addr_o,       32'h24);
        checkOutput("b2b dbg ack early",    32'(bus.dbg_ack_o),   32'd0);
        nextCycle();
        checkOutput("b2b dbg ack",          32'(bus.dbg_ack_o),   32'd1);
        checkOutput("b2b dbg write rdata",  bus.dbg_rdata_o,      32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("b2b mem[0x24]", mem[9], 32'h5555_AAAA);

        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h30, 32'hBBBB_BBBB);
        nextCycle();
        checkOutput("abort write strobe", 32'(bus.mem_write_o), 32'd1);
        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        checkAllZero("reset in busy");
        nextCycle();
        checkAllZero("reset held");
        rst_i = 1'b0;
        nextCycle();
        checkOutput("abort no ack",     32'(bus.dbg_ack_o),   32'd0);
        checkOutput("abort idle write", 32'(bus.mem_write_o), 32'd0);
        checkOutput("abort mem[0x30]",  mem[12],              32'hAAAA_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-port data memory between the pipeline's MEM stage and a debug/loader master. Each access is registered, so the CPU is stalled for every data-memory access until completion. Requests from the two masters are serialised. Default policy is round-robin; CPU-fixed-priority is selectable at compile time. The block sits between the EX/MEM pipeline register outputs and the Data_Memory instance, and its stall output drives pipeline-register hold and PC hold.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- cpu_req_i  in  1  CPU access request (EX_MEM MemRead|MemWrite); held until cpu_ack_o
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_addr_i  in  AW  word-aligned byte address
- cpu_wdata_i  in  DW  write data
- cpu_ack_o  out  1  one-cycle completion pulse
- cpu_rdata_o  out  DW  read data, valid with cpu_ack_o
- cpu_stall_o  out  1  cpu_req_i & ~cpu_ack_o (combinational)
- dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i  in  1/1/AW/DW  debug master, same protocol as CPU
- dbg_ack_o, dbg_rdata_o  out  1/DW  debug completion and read data
- mem_addr_o, mem_wdata_o  out  AW/DW  to memory, from latched command
- mem_read_o, mem_write_o  out  1/1  memory strobes
- mem_rdata_i  in  DW  memory read data (combinational memory read)

## Operation
- FSM states: IDLE, BUSY, DONE. Owner register: CPU or DBG. last_owner register for round-robin.
- IDLE:
  - If any request is high, pick a winner and latch {we, addr, wdata}, owner := winner, then go to BUSY.
  - If both requests are high, the winner is the master that is not last_owner.
- BUSY:
  - mem_read_o = ~we, mem_write_o = we. mem_addr_o and mem_wdata_o come from the latched command.
  - The write commits at the edge ending BUSY. The rdata register captures mem_rdata_i at the same edge.
  - last_owner := owner. Go to DONE.
- DONE:
  - Assert the owner's ack_o. The owner's rdata_o holds the captured data (zero for writes).
  - If the non-owner's request is high, latch its command and go directly to BUSY (back-to-back).
  - Otherwise go to IDLE.
  - The owner's still-high request is ignored in DONE.
- Protocol: a master keeps req and its fields stable from assertion until its ack cycle, and deasserts req (or presents a new access) after the ack edge.
  - Dropping req before ack is illegal. The access still completes and ack still pulses; the bench flags this with an assertion.
- Addresses are forwarded unmodified; addr[1:0] ≠ 0 is a protocol error and is not corrected.

## Timing
- Uncontended access: req seen in IDLE at cycle N, BUSY at N+1, ack plus rdata at N+2. cpu_stall_o is high in cycles N and N+1, low in N+2.
- Contended access: the loser's ack arrives 2 cycles after the winner's ack. Peak throughput is 1 access per 2 cycles under back-to-back.
- Reset values: state = IDLE, owner = CPU, last_owner = DBG (so the CPU wins the first tie). All acks, mem strobes, rdata, mem_addr_o and mem_wdata_o are 0.
- Reset asserted during BUSY:
  - mem_write_o drops immediately, because it is decoded from registered state.
  - The write is aborted, no ack is issued, and the FSM restarts in IDLE after release.

## Configuration
- DMEM_ARB_CPU_PRIO_EN
  - Defined: in IDLE the CPU always wins a tie and last_owner is ignored. DONE back-to-back handoff is unchanged, so DBG is served after each CPU access if it is waiting.
  - Undefined: round-robin as described above.

## Structure
- Package dmem_arb_pkg holds:
  - state encoding: IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2
  - owner encoding: OWN_CPU = 1'b0, OWN_DBG = 1'b1
- One sub-module, rr_arb2: a two-requester combinational picker taking (req0, req1, last, prio_en) and returning the winner. It contains the macro-dependent logic.
- The FSM, command latch and rdata register stay in the top module.

## Test plan
- CPU read only: preload mem[0x10] = 0xDEADBEEF, cpu_req at cycle 2 → stall high in cycles 2–3; cpu_ack plus rdata 0xDEADBEEF at cycle 4.
- CPU write then read: write 0x12345678 to 0x20, then read 0x20 → second ack returns 0x12345678; mem_write_o asserted for exactly one cycle.
- Simultaneous requests after reset: CPU read 0x0 and DBG read 0x4 → CPU ack at cycle N+2, DBG ack at N+4. Next tie goes to the CPU under round-robin.
- DMEM_ARB_CPU_PRIO_EN defined: three successive ties → CPU wins in IDLE each time; DBG is served via the DONE handoff; no master waits more than 4 cycles.
- Reset in BUSY of a DBG write to 0x30 (old value 0xAAAA0000) → no ack, mem[0x30] still 0xAAAA0000, all outputs zero during reset.
- Back-to-back: DBG request held high while the CPU is in BUSY → DONE goes directly to BUSY; DBG ack arrives exactly 2 cycles after the CPU ack.
